// File: rtl/ads131a0x_pwr_sequencer.sv
// ads131a0x_pwr_sequencer: Avalon-MM master that sequences the ADS131A0X power/reset PIO
//
// Purpose
//   Sole writer of the 2-bit ADC control PIO (bit1 = ADC_EN, bit0 = ADC_RESET_N).
//   start_i powers the ADC with reset held, releases reset after PWR_CYCLES and
//   then waits for ready_i. stop_i (or an abort during power-up) writes 2'b10,
//   holds reset for RST_CYCLES, then writes 2'b00.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   start_i, stop_i    1-cycle command pulses
//   ready_i            ADC ready level from the SPI core
//   busy_o, up_o       sequence running / ADC up and ready
//   err_o              ready timeout, sticky until the next accepted start_i
//   m_address, m_chipselect, m_write_n, m_writedata, m_waitrequest  Avalon-MM master
//
// Configuration
//   ADS131A0X_SEQ_TIMEOUT_EN  when defined, W_RDY gives up after TMO_CYCLES and
//                             shuts down with err_o set; otherwise it waits forever
//                             and err_o is tied 0.
module ads131a0x_pwr_sequencer #(
    parameter int PWR_CYCLES = 1000,
    parameter int RST_CYCLES = 64,
    parameter int TMO_CYCLES = 65535,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        up_o,
    output logic        err_o,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);
    typedef enum logic [3:0] {
        OFF, WR_PWR, T_PWR, WR_REL, W_RDY, ON, WR_RST, T_RST, WR_OFF
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             up_q, up_d;
    logic             cs_q, cs_d;
    logic [1:0]       pio_q, pio_d;
    logic             acc, pend;

    if (PWR_CYCLES < 1 || RST_CYCLES < 1 || TMO_CYCLES < 1) begin : g_bad_param
        $error("ads131a0x_pwr_sequencer: *_CYCLES parameters must be >= 1");
    end

`ifdef ADS131A0X_SEQ_TIMEOUT_EN
    logic err_q, err_d, tmo;
    assign tmo = (cnt_q == CNT_W'(TMO_CYCLES - 1));
`endif

    always_comb begin
        acc     = !m_waitrequest;
        // a stop seen while a power-up write is stalled is remembered until the write lands
        pend    = abort_q | stop_i;
        cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        case (state_q)
            OFF:     if (start_i) state_d = WR_PWR;
            WR_PWR:  if (acc) begin
                         state_d = pend ? WR_RST : T_PWR;
                         cnt_d   = '0;
                     end else abort_d = pend;
            T_PWR:   if (stop_i) state_d = WR_RST;
                     else if (cnt_q == CNT_W'(PWR_CYCLES - 1)) state_d = WR_REL;
                     else cnt_d = cnt_inc;
            WR_REL:  if (acc) begin
                         state_d = pend ? WR_RST : W_RDY;
                         cnt_d   = '0;
                     end else abort_d = pend;
`ifdef ADS131A0X_SEQ_TIMEOUT_EN
            W_RDY:   if (stop_i) state_d = WR_RST;
                     else if (ready_i) state_d = ON;
                     else if (tmo) state_d = WR_RST;
                     else cnt_d = cnt_inc;
`else
            W_RDY:   if (stop_i) state_d = WR_RST;
                     else if (ready_i) state_d = ON;
`endif
            ON:      if (stop_i) state_d = WR_RST;
            WR_RST:  if (acc) begin
                         state_d = T_RST;
                         cnt_d   = '0;
                     end
            T_RST:   if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WR_OFF;
                     else cnt_d = cnt_inc;
            WR_OFF:  if (acc) state_d = OFF;
            default: state_d = OFF;
        endcase
        // outputs are registered copies of the next-state decode so they line up with state_q
        cs_d   = state_d inside {WR_PWR, WR_REL, WR_RST, WR_OFF};
        busy_d = !(state_d inside {OFF, ON});
        up_d   = (state_d == ON);
        pio_d  = (state_d == WR_REL) ? 2'b11 :
                 (state_d == WR_PWR || state_d == WR_RST) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            up_q    <= 1'b0;
            cs_q    <= 1'b0;
            pio_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            up_q    <= up_d;
            cs_q    <= cs_d;
            pio_q   <= pio_d;
        end
    end

`ifdef ADS131A0X_SEQ_TIMEOUT_EN
    always_comb begin
        err_d = err_q;
        if (state_q == OFF && start_i) err_d = 1'b0;
        else if (state_q == W_RDY && !stop_i && !ready_i && tmo) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o       = busy_q;
    assign up_o         = up_q;
    assign m_address    = 2'b00;
    assign m_chipselect = cs_q;
    assign m_write_n    = !cs_q;
    assign m_writedata  = {30'b0, pio_q};
endmodule
